// File: rtl/booth_mult_ctrl_pkg.sv
// Shared multdiv constants: FSM state encodings, operand/product widths and group indices.
// Also holds the early-termination predicate used when MULT_EARLY_TERM_EN is defined.
package booth_mult_ctrl_pkg;

  localparam int unsigned OpaW    = 16;
  localparam int unsigned OpbW    = 16;
  localparam int unsigned ProdW   = 32;
  localparam int unsigned NGroups = OpbW / 2;
  localparam int unsigned CntW    = 3;

  localparam logic [CntW-1:0] LastGroup = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // True when multiplier bits [15:2*grp+1] are all equal, i.e. every Booth group above grp
  // decodes to a zero digit. The arithmetic shift fills with the sign bit, so comparing the
  // whole shifted value against all-0/all-1 is the same as checking just those bits.
  function automatic logic upper_uniform(input logic [OpbW-1:0] mul, input logic [CntW-1:0] grp);
    logic signed [OpbW-1:0] s;
    s = mul;
    s = s >>> (int'(grp) * 2 + 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/booth_mult_ctrl_acc.sv
// Product accumulator: 32-bit register with synchronous clear, load enable and an adder that
// folds in the Booth negation carry. sum_o exposes the next accumulated value so the caller
// can capture the final product on the same edge the last group is added.
module booth_mult_ctrl_acc
  import booth_mult_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [ProdW-1:0] addend_i,
  input  logic             cin_i,
  output logic [ProdW-1:0] sum_o
);

  logic [ProdW-1:0] acc_q;
  logic [ProdW-1:0] acc_d;

  // Modulo-2^32 sum of accumulator, partial product and carry-in.
  always_comb begin
    sum_o = acc_q + addend_i + {{(ProdW-1){1'b0}}, cin_i};
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_o;
    end
  end

  // Accumulator state; clear wins over enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential control/accumulate stage behind the radix-4 Booth partial-product stage.
// Latches a signed 16x16 operand pair, walks group index 0..7 and sums the returned partial
// products into a 32-bit signed product, pulsing data_resultRDY for one cycle when done.
// Optional: define MULT_EARLY_TERM_EN to finish as soon as all remaining groups are zero.
module booth_mult_ctrl
  import booth_mult_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [OpaW-1:0]  data_operandA,
  input  logic [OpbW-1:0]  data_operandB,
  output logic [ProdW-1:0] booth_multiplicand,
  output logic [OpbW-1:0]  booth_multiplier,
  output logic [CntW-1:0]  booth_counter,
  input  logic [ProdW-1:0] booth_output,
  input  logic             booth_carry,
  output logic [ProdW-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_inputRDY
);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [ProdW-1:0] opa_q;
  logic [OpbW-1:0]  opb_q;
  logic [ProdW-1:0] result_q;
  logic             result_rdy_q;
  logic             input_rdy_q;

  logic             start;
  logic             acc_en;
  logic             last_grp;
  logic [ProdW-1:0] acc_sum;

  // Start is only honoured while idle or presenting a result; RUN ignores ctrl_MULT.
  always_comb begin
    start  = ctrl_MULT && ((state_q == StIdle) || (state_q == StDone));
    acc_en = (state_q == StRun);
`ifdef MULT_EARLY_TERM_EN
    last_grp = (cnt_q == LastGroup) || upper_uniform(opb_q, cnt_q);
`else
    last_grp = (cnt_q == LastGroup);
`endif
  end

  booth_mult_ctrl_acc u_acc (
    .clk_i    (clock),
    .rst_i    (reset),
    .clr_i    (start),
    .en_i     (acc_en),
    .addend_i (booth_output),
    .cin_i    (booth_carry),
    .sum_o    (acc_sum)
  );

  // Control FSM, group counter, operand latches and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
      result_rdy_q <= 1'b0;
      input_rdy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          result_rdy_q <= 1'b0;
          if (ctrl_MULT) begin
            opa_q       <= {{(ProdW-OpaW){data_operandA[OpaW-1]}}, data_operandA};
            opb_q       <= data_operandB;
            cnt_q       <= '0;
            input_rdy_q <= 1'b0;
            state_q     <= StRun;
          end else begin
            input_rdy_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StRun: begin
          if (last_grp) begin
            result_q     <= acc_sum;
            result_rdy_q <= 1'b1;
            input_rdy_q  <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StDone;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
          state_q     <= StIdle;
          cnt_q       <= '0;
          input_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign booth_multiplicand = opa_q;
  assign booth_multiplier   = opb_q;
  assign booth_counter      = cnt_q;
  assign data_result        = result_q;
  assign data_resultRDY     = result_rdy_q;
  assign data_inputRDY      = input_rdy_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl with a behavioural radix-4 Booth partial-product stage.
// Latency expectations follow MULT_EARLY_TERM_EN when the bench is built with it defined.
module tb_booth_mult_ctrl;

`ifdef MULT_EARLY_TERM_EN
  localparam int L35 = 2, L76 = 2, LM1 = 1, L8K = 8, L0M1 = 1, L1234 = 1, L100M2 = 1;
`else
  localparam int L35 = 8, L76 = 8, LM1 = 8, L8K = 8, L0M1 = 8, L1234 = 8, L100M2 = 8;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [15:0] data_operandA;
  logic [15:0] data_operandB;
  logic [31:0] booth_multiplicand;
  logic [15:0] booth_multiplier;
  logic [2:0]  booth_counter;
  logic [31:0] booth_output;
  logic        booth_carry;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_inputRDY;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  booth_mult_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .ctrl_MULT          (ctrl_MULT),
    .data_operandA      (data_operandA),
    .data_operandB      (data_operandB),
    .booth_multiplicand (booth_multiplicand),
    .booth_multiplier   (booth_multiplier),
    .booth_counter      (booth_counter),
    .booth_output       (booth_output),
    .booth_carry        (booth_carry),
    .data_result        (data_result),
    .data_resultRDY     (data_resultRDY),
    .data_inputRDY      (data_inputRDY)
  );

  // Radix-4 Booth partial product for the selected group; negation as ~x with carry 1.
  logic [16:0] bx;
  logic [2:0]  trip;
  logic [31:0] pp;
  logic [31:0] pp_sh;
  logic        neg;
  int          grp;
  always_comb begin
    bx    = {booth_multiplier, 1'b0};
    grp   = int'(booth_counter);
    trip  = bx[2*grp +: 3];
    pp    = '0;
    case (trip)
      3'b001, 3'b010, 3'b101, 3'b110: pp = booth_multiplicand;
      3'b011, 3'b100:                 pp = booth_multiplicand << 1;
      default:                        pp = '0;
    endcase
    neg          = trip[2] && (trip != 3'b111);
    pp_sh        = pp << (2 * grp);
    booth_output = neg ? ~pp_sh : pp_sh;
    booth_carry  = neg;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with ctrl_MULT for one edge, then confirm the block went busy.
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    check("busy_inputRDY", {31'd0, data_inputRDY}, 32'd0);
  endtask

  // Count edges after the start edge until resultRDY, bounded.
  task automatic wait_result(input string tag, input logic [31:0] exp, input int lat);
    int n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        n = i;
        break;
      end
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_result"}, data_result, exp);
  endtask

  // One edge after DONE: pulse gone, idle, result held.
  task automatic check_idle(input string tag, input logic [31:0] exp);
    @(posedge clock);
    #1;
    check({tag, "_rdy_low"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_inputRDY"}, {31'd0, data_inputRDY}, 32'd1);
    check({tag, "_held"}, data_result, exp);
    check({tag, "_counter"}, {29'd0, booth_counter}, 32'd0);
  endtask

  initial begin
    int pulses;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #12;
    check("rst_result", data_result, 32'd0);
    check("rst_resultRDY", {31'd0, data_resultRDY}, 32'd0);
    check("rst_inputRDY", {31'd0, data_inputRDY}, 32'd1);
    check("rst_counter", {29'd0, booth_counter}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    start(16'd3, 16'd5);
    check("run_counter0", {29'd0, booth_counter}, 32'd0);
    wait_result("3x5", 32'h0000_000F, L35);
    check_idle("3x5", 32'h0000_000F);

    start(16'hFFF9, 16'd6);
    wait_result("m7x6", 32'hFFFF_FFD6, L76);
    check_idle("m7x6", 32'hFFFF_FFD6);

    start(16'h7FFF, 16'hFFFF);
    wait_result("32767xm1", 32'hFFFF_8001, LM1);

    start(16'h8000, 16'h8000);
    wait_result("m32768sq", 32'h4000_0000, L8K);

    start(16'h0000, 16'hFFFF);
    wait_result("0xm1", 32'h0000_0000, L0M1);
    check_idle("0xm1", 32'h0000_0000);

    // Start again and operand changes mid-RUN must be ignored: 100 x 0x5555 = 2184500.
    start(16'd100, 16'h5555);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 16'd9;
    data_operandB = 16'd9;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_result", data_result, 32'h0021_5534);

    // Reset during RUN cycle 4 aborts with no pulse and clears the result.
    start(16'd100, 16'h5555);
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_result", data_result, 32'd0);
    check("abort_inputRDY", {31'd0, data_inputRDY}, 32'd1);
    check("abort_counter", {29'd0, booth_counter}, 32'd0);
    @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    check("abort_pulses", pulses, 0);
    start(16'hFFF9, 16'd6);
    wait_result("after_abort", 32'hFFFF_FFD6, L76);

    start(16'd1234, 16'd1);
    wait_result("1234x1", 32'h0000_04D2, L1234);

    // Multiplier 0xFFFE has all-ones above bit 0, so early termination ends after group 0.
    start(16'd100, 16'hFFFE);
    wait_result("100xm2", 32'hFFFF_FF38, L100M2);
    // Back-to-back: start issued while still in DONE.
    start(16'd3, 16'd5);
    wait_result("b2b_3x5", 32'h0000_000F, L35);
    check_idle("b2b", 32'h0000_000F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
